// File: rtl/native_pkg.sv
// Shared defaults and types for the native_synth batch scheduler.
// Contents: default engine/batch geometry and the scheduler FSM state type.
package native_pkg;

    localparam int N            = 128;
    localparam int WEIGHT_WIDTH = 4;
    localparam int ACT_WIDTH    = 4;
    localparam int RESULT_WIDTH = 16;
    localparam int BATCH_W      = 16;
    localparam int FIFO_DEPTH   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/native_result_fifo.sv
// Synchronous result FIFO. The head entry comes straight from the storage
// registers and reads as zero while empty, so the output is stable between pops.
// Ports:
//   clk, rst       clock, synchronous active-high reset (flushes the FIFO)
//   wr_en, wr_data push request; ignored while full
//   rd_en          pop request; ignored while empty
//   rd_data        head-of-FIFO entry
//   full, empty    occupancy flags
module native_result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/native_batch_ctrl.sv
// Batch scheduler for the native_synth dot-product engine. Streams operand
// vectors from a banked buffer into the engine, collects results in a FIFO and
// presents them on a valid/ready stream. Issue is credit-limited so the
// non-stallable engine can never overrun the FIFO.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_start, cfg_batch_num      run launch and batch count (sampled in IDLE)
//   busy, done_pulse, err_overflow run status
//   rd_en, rd_addr, rd_*_flat     operand buffer read (data one cycle later)
//   eng_start, eng_*_flat         engine issue
//   eng_done, eng_result          engine result (fixed latency)
//   o_valid/o_ready/o_result/o_index/o_last  result stream
module native_batch_ctrl #(
    parameter int N            = native_pkg::N,
    parameter int WEIGHT_WIDTH = native_pkg::WEIGHT_WIDTH,
    parameter int ACT_WIDTH    = native_pkg::ACT_WIDTH,
    parameter int RESULT_WIDTH = native_pkg::RESULT_WIDTH,
    parameter int BATCH_W      = native_pkg::BATCH_W,
    parameter int FIFO_DEPTH   = native_pkg::FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_start,
    input  logic [BATCH_W-1:0]        cfg_batch_num,
    output logic                      busy,
    output logic                      done_pulse,
    output logic                      err_overflow,
    output logic                      rd_en,
    output logic [BATCH_W-1:0]        rd_addr,
    input  logic [N*WEIGHT_WIDTH-1:0] rd_weights_flat,
    input  logic [N*ACT_WIDTH-1:0]    rd_acts_flat,
    output logic                      eng_start,
    output logic [N*WEIGHT_WIDTH-1:0] eng_weights_flat,
    output logic [N*ACT_WIDTH-1:0]    eng_acts_flat,
    input  logic                      eng_done,
    input  logic [RESULT_WIDTH-1:0]   eng_result,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [RESULT_WIDTH-1:0]   o_result,
    output logic [BATCH_W-1:0]        o_index,
    output logic                      o_last
);

    import native_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = RESULT_WIDTH + BATCH_W + 1;

    state_t             state_q, state_d;
    logic               done_d;
    logic [BATCH_W-1:0] batch_num_q;
    logic [BATCH_W-1:0] issued_q;
    logic [BATCH_W-1:0] popped_q;
    logic [BATCH_W-1:0] wr_idx_q;
    logic [CW-1:0]      credits_q;
    logic               eng_start_q;
    logic               done_q;
    logic               err_q;

    logic               accept;
    logic               issue;
    logic               pop;
    logic               last_pop;
    logic               res_in;
    logic               overflow;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FW-1:0]      fifo_din;
    logic [FW-1:0]      fifo_dout;

    assign accept   = (state_q == IDLE) && cfg_start;
    assign issue    = (state_q == RUN) && (issued_q < batch_num_q) && (credits_q != '0);
    assign pop      = o_valid && o_ready;
    assign last_pop = pop && (popped_q == batch_num_q - 1'b1);
    // Results landing while IDLE belong to a run discarded by reset.
    assign res_in   = eng_done && (state_q != IDLE);
    assign overflow = res_in && fifo_full;
    assign fifo_din = {eng_result, wr_idx_q, (wr_idx_q == batch_num_q - 1'b1)};

    native_result_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (res_in),
        .wr_data (fifo_din),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cfg_batch_num == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (issued_q == batch_num_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            eng_start_q <= 1'b0;
            batch_num_q <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            wr_idx_q    <= '0;
            err_q       <= 1'b0;
            credits_q   <= CW'(FIFO_DEPTH);
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            eng_start_q <= issue;
            if (accept) begin
                batch_num_q <= cfg_batch_num;
                issued_q    <= '0;
                popped_q    <= '0;
                wr_idx_q    <= '0;
                err_q       <= 1'b0;
            end else begin
                if (issue)    issued_q <= issued_q + 1'b1;
                if (pop)      popped_q <= popped_q + 1'b1;
                if (res_in)   wr_idx_q <= wr_idx_q + 1'b1;
                if (overflow) err_q    <= 1'b1;
            end
            case ({issue, pop})
                2'b10:   credits_q <= credits_q - 1'b1;
                2'b01:   credits_q <= credits_q + 1'b1;
                default: credits_q <= credits_q;
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign done_pulse   = done_q;
    assign err_overflow = err_q;
    assign rd_en        = issue;
    assign rd_addr      = issued_q;
    assign eng_start    = eng_start_q;
    // Buffer data arrives exactly in the eng_start cycle; gate so the engine
    // bus reads zero outside an issue.
    assign eng_weights_flat = eng_start_q ? rd_weights_flat : '0;
    assign eng_acts_flat    = eng_start_q ? rd_acts_flat    : '0;

    assign o_valid  = !fifo_empty;
    assign o_result = fifo_dout[FW-1 -: RESULT_WIDTH];
    assign o_index  = fifo_dout[BATCH_W:1];
    assign o_last   = fifo_dout[0];

endmodule

// File: tb/tb_native_batch_ctrl.sv
module tb_native_batch_ctrl;

    localparam int N       = 128;
    localparam int WW      = 4;
    localparam int ACTW    = 4;
    localparam int RW      = 16;
    localparam int BW      = 16;
    localparam int DEPTH   = 4;
    localparam int ENG_LAT = 3;

    logic              clk;
    logic              rst;
    logic              cfg_start;
    logic [BW-1:0]     cfg_batch_num;
    logic              busy, done_pulse, err_overflow;
    logic              rd_en;
    logic [BW-1:0]     rd_addr;
    logic [N*WW-1:0]   rd_weights_flat;
    logic [N*ACTW-1:0] rd_acts_flat;
    logic              eng_start;
    logic [N*WW-1:0]   eng_weights_flat;
    logic [N*ACTW-1:0] eng_acts_flat;
    logic              eng_done;
    logic [RW-1:0]     eng_result;
    logic              o_valid, o_ready, o_last;
    logic [RW-1:0]     o_result;
    logic [BW-1:0]     o_index;

    native_batch_ctrl #(
        .N(N), .WEIGHT_WIDTH(WW), .ACT_WIDTH(ACTW), .RESULT_WIDTH(RW),
        .BATCH_W(BW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_batch_num(cfg_batch_num),
        .busy(busy), .done_pulse(done_pulse), .err_overflow(err_overflow),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_weights_flat(rd_weights_flat),
        .rd_acts_flat(rd_acts_flat), .eng_start(eng_start),
        .eng_weights_flat(eng_weights_flat), .eng_acts_flat(eng_acts_flat),
        .eng_done(eng_done), .eng_result(eng_result), .o_valid(o_valid),
        .o_ready(o_ready), .o_result(o_result), .o_index(o_index), .o_last(o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*WW-1:0] gen_w(input int b);
        logic [N*WW-1:0] w;
        for (int i = 0; i < N; i++) w[i*WW +: WW] = WW'(b * 5 + i * 3 + 1);
        return w;
    endfunction

    function automatic logic [N*ACTW-1:0] gen_a(input int b);
        logic [N*ACTW-1:0] a;
        for (int i = 0; i < N; i++) a[i*ACTW +: ACTW] = ACTW'(b * 11 + i * 7 + 2);
        return a;
    endfunction

    // signed weights x unsigned activations
    function automatic logic [RW-1:0] dot(input logic [N*WW-1:0] w, input logic [N*ACTW-1:0] a);
        int s = 0;
        for (int i = 0; i < N; i++)
            s += int'($signed(w[i*WW +: WW])) * int'(a[i*ACTW +: ACTW]);
        return RW'(s);
    endfunction

    typedef struct {
        logic [RW-1:0] res;
        logic [BW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   issue_cyc[$];
    int   cyc = 0;
    int   exp_addr = 0;
    int   run_num = 0;
    int   issues = 0;
    int   pops = 0;
    int   last_pop_cyc = -1;
    int   ready_mode = 1;   // 0 low, 1 high, 2 random
    bit   sb_on = 1'b1;
    bit   inj = 1'b0;

    // Operand buffer, engine and result sink models; all act at the falling edge.
    initial begin : models
        logic          pv [ENG_LAT];
        logic [RW-1:0] pr [ENG_LAT];
        logic          hold_v;
        logic [RW-1:0] h_res;
        logic [BW-1:0] h_idx;
        logic          h_last;
        logic [RW-1:0] e_r;
        exp_t          e;
        for (int k = 0; k < ENG_LAT; k++) begin pv[k] = 1'b0; pr[k] = '0; end
        hold_v = 1'b0; h_res = '0; h_idx = '0; h_last = 1'b0;
        rd_weights_flat = '0; rd_acts_flat = '0;
        eng_done = 1'b0; eng_result = '0; o_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                hold_v = 1'b0;
            end else if (hold_v) begin
                check("hold_valid", o_valid, 1'b1);
                check("hold_result", o_result, h_res);
                check("hold_index", o_index, h_idx);
                check("hold_last", o_last, h_last);
            end
            // engine: sample issue, advance pipeline
            e_r = eng_start ? dot(eng_weights_flat, eng_acts_flat) : '0;
            for (int k = ENG_LAT - 1; k > 0; k--) begin pv[k] = pv[k-1]; pr[k] = pr[k-1]; end
            pv[0] = eng_start; pr[0] = e_r;
            eng_done   = pv[ENG_LAT-1] | inj;
            eng_result = inj ? 16'h7abc : pr[ENG_LAT-1];
            // operand buffer read
            if (rd_en) begin
                check("credit_bound", (issues - pops) < DEPTH, 1'b1);
                if (sb_on) begin
                    check("rd_addr", rd_addr, exp_addr);
                    sb.push_back('{dot(gen_w(exp_addr), gen_a(exp_addr)), BW'(exp_addr),
                                   exp_addr == run_num - 1});
                end
                issue_cyc.push_back(cyc);
                exp_addr++;
                issues++;
                rd_weights_flat = gen_w(int'(rd_addr));
                rd_acts_flat    = gen_a(int'(rd_addr));
            end
            // result sink
            case (ready_mode)
                0:       o_ready = 1'b0;
                1:       o_ready = 1'b1;
                default: o_ready = 1'($urandom_range(0, 1));
            endcase
            if (o_valid && o_ready) begin
                pops++;
                last_pop_cyc = cyc;
                hold_v = 1'b0;
                if (sb_on) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 1'b1, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        check("o_result", o_result, e.res);
                        check("o_index", o_index, e.idx);
                        check("o_last", o_last, e.last);
                    end
                end
            end else begin
                hold_v = o_valid;
                h_res = o_result; h_idx = o_index; h_last = o_last;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Drives cfg_start for one cycle; returns one cycle after acceptance.
    task automatic start(input int n);
        run_num = n;
        exp_addr = 0;
        issue_cyc.delete();
        cfg_batch_num = BW'(n);
        cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit after_pop);
        int i = 0;
        while (!done_pulse && i < budget) begin
            step(1);
            i++;
        end
        check("done_seen", done_pulse, 1'b1);
        check("busy_at_done", busy, 1'b0);
        if (after_pop) check("done_latency", cyc - last_pop_cyc, 1);
        check("sb_drained", sb.size() == 0, 1'b1);
        step(1);
        check("done_one_cycle", done_pulse, 1'b0);
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst = 1'b1; cfg_start = 1'b0; cfg_batch_num = '0;
        step(3);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done_pulse, 1'b0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_eng_start", eng_start, 1'b0);
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_o_last", o_last, 1'b0);
        check("rst_err", err_overflow, 1'b0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_o_index", o_index, 0);
        check("rst_o_result", o_result, 0);
        check("rst_eng_flat", (eng_weights_flat == '0) && (eng_acts_flat == '0), 1'b1);
        rst = 1'b0;
        step(1);

        // basic run
        ready_mode = 1;
        start(4);
        check("t1_busy", busy, 1'b1);
        check("t1_rd_en", rd_en, 1'b1);
        step(1);
        check("t2_eng_start", eng_start, 1'b1);
        wait_done(100, 1);
        check("basic_issues", issue_cyc.size(), 4);
        if (issue_cyc.size() == 4) check("basic_back_to_back", issue_cyc[3] - issue_cyc[0], 3);

        // throttle by credits
        ready_mode = 0;
        start(10);
        step(20);
        check("throttle_issues", issue_cyc.size(), 4);
        check("throttle_rd_en_low", rd_en, 1'b0);
        check("throttle_full_valid", o_valid, 1'b1);
        ready_mode = 1;
        wait_done(200, 1);
        check("throttle_all_issued", issue_cyc.size(), 10);
        check("throttle_no_err", err_overflow, 1'b0);

        // zero batches
        start(0);
        check("zero_done", done_pulse, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_rd_en", rd_en, 1'b0);
        step(1);
        check("zero_done_clear", done_pulse, 1'b0);
        check("zero_no_issue", issue_cyc.size(), 0);

        // cfg_start during RUN ignored
        start(6);
        step(1);
        cfg_batch_num = BW'(1);
        cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        wait_done(200, 1);
        check("ignore_issues", issue_cyc.size(), 6);

        // random backpressure
        ready_mode = 2;
        start(1024);
        wait_done(20000, 1);
        check("random_issues", issue_cyc.size(), 1024);
        ready_mode = 1;

        // reset mid-run
        ready_mode = 0;
        start(8);
        step(4);
        rst = 1'b1;
        step(1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd_en", rd_en, 1'b0);
        check("mid_rst_eng_start", eng_start, 1'b0);
        check("mid_rst_o_valid", o_valid, 1'b0);
        check("mid_rst_o_last", o_last, 1'b0);
        check("mid_rst_o_result", o_result, 0);
        check("mid_rst_o_index", o_index, 0);
        check("mid_rst_rd_addr", rd_addr, 0);
        rst = 1'b0;
        sb.delete();
        issues = 0;
        pops = 0;
        step(8);
        check("post_rst_no_valid", o_valid, 1'b0);
        check("post_rst_no_err", err_overflow, 1'b0);
        ready_mode = 1;
        start(2);
        wait_done(100, 1);
        check("post_rst_issues", issue_cyc.size(), 2);

        // overflow fault
        sb_on = 1'b0;
        ready_mode = 0;
        start(6);
        step(12);
        check("fault_fifo_full", o_valid, 1'b1);
        check("fault_err_before", err_overflow, 1'b0);
        inj = 1'b1;
        step(1);
        inj = 1'b0;
        step(1);
        check("fault_err_set", err_overflow, 1'b1);
        ready_mode = 1;
        wait_done(200, 1);
        check("fault_err_sticky", err_overflow, 1'b1);
        sb_on = 1'b1;
        start(2);
        check("fault_err_cleared", err_overflow, 1'b0);
        wait_done(100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
